// File: rtl/fifo_flow_ctrl_fsm.sv
// fifo_flow_ctrl_fsm
// Supervises NCH FIFO channels from their occupancy counts. Per channel it
// derives a backpressure bit (pause) from programmable almost-full /
// almost-empty thresholds with hysteresis. It also latches sticky overflow
// flags and reports a global state code.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   init         configuration request; thresholds are sampled while in INIT
//   umbral_af_in almost-full threshold candidate
//   umbral_ae_in almost-empty threshold candidate
//   fifo_count   per-channel occupancy, channel i at [i*CNT_W +: CNT_W]
//   fifo_full    per-channel full flags
//   fifo_empty   per-channel empty flags
//   state        0 RESET, 1 INIT, 2 IDLE, 3 ACTIVE, 4 ERROR
//   pause        per-channel backpressure (registered)
//   error_full   sticky per-channel overflow flags (registered)
//   cfg_err      last configuration was rejected and defaults were loaded
//   idle         high exactly when state==IDLE
//   stall_to     (FIFO_FLOW_STALL_TIMEOUT_EN only) sticky per-channel stall timeout
//
// Optional feature macro: FIFO_FLOW_STALL_TIMEOUT_EN adds the TIMEOUT parameter
// and the stall_to output. When a channel stays paused in ACTIVE for TIMEOUT
// cycles, its stall_to bit is set and the FSM enters ERROR.
module fifo_flow_ctrl_fsm #(
  parameter int NCH        = 4,
  parameter int CNT_W      = 3,
  parameter int AF_DEFAULT = 6,
  parameter int AE_DEFAULT = 1
`ifdef FIFO_FLOW_STALL_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 16
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init,
  input  logic [CNT_W-1:0]   umbral_af_in,
  input  logic [CNT_W-1:0]   umbral_ae_in,
  input  logic [NCH*CNT_W-1:0] fifo_count,
  input  logic [NCH-1:0]     fifo_full,
  input  logic [NCH-1:0]     fifo_empty,
  output logic [2:0]         state,
  output logic [NCH-1:0]     pause,
  output logic [NCH-1:0]     error_full,
  output logic               cfg_err,
`ifdef FIFO_FLOW_STALL_TIMEOUT_EN
  output logic [NCH-1:0]     stall_to,
`endif
  output logic               idle
);

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_IDLE   = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  localparam logic [CNT_W-1:0] AF_DEF = CNT_W'(AF_DEFAULT);
  localparam logic [CNT_W-1:0] AE_DEF = CNT_W'(AE_DEFAULT);

  logic [2:0]       state_reg, state_next;
  logic [NCH-1:0]   pause_reg, pause_next;
  logic [NCH-1:0]   error_full_reg, error_full_next;
  logic             cfg_err_reg, cfg_err_next;
  logic             idle_reg, idle_next;
  logic [CNT_W-1:0] af_reg, af_next;
  logic [CNT_W-1:0] ae_reg, ae_next;
  logic [CNT_W-1:0] cand_af_reg, cand_af_next;
  logic [CNT_W-1:0] cand_ae_reg, cand_ae_next;
  logic             sampled_reg, sampled_next;

  logic [NCH-1:0]   hyst;        // hysteresis result per channel
  logic             any_full;
  logic             any_busy;
  logic             stall_any;
  logic             in_run;      // IDLE or ACTIVE

  assign any_full = |fifo_full;
  assign any_busy = |(~fifo_empty);
  assign in_run   = (state_reg == S_IDLE) || (state_reg == S_ACTIVE);

  // Per-channel hysteresis: set at/above af, clear at/below ae, else hold.
  // Set wins if both conditions are met at once.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_hyst
      logic [CNT_W-1:0] cnt_ch;
      assign cnt_ch = fifo_count[gi*CNT_W +: CNT_W];
      assign hyst[gi] = (cnt_ch >= af_reg) ? 1'b1 :
                        (cnt_ch <= ae_reg) ? 1'b0 : pause_reg[gi];
    end
  endgenerate

`ifdef FIFO_FLOW_STALL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [NCH-1:0] stall_hit;
  logic [NCH-1:0] stall_to_reg;

  generate
    for (gi = 0; gi < NCH; gi++) begin : g_stall
      logic [TO_W-1:0] to_cnt_reg;
      // The edge that would bring the count to TIMEOUT is the timeout edge.
      assign stall_hit[gi] = (state_reg == S_ACTIVE) && pause_reg[gi] &&
                             (to_cnt_reg == TO_W'(TIMEOUT - 1));
      always_ff @(posedge clk) begin
        if (reset)
          to_cnt_reg <= '0;
        else if (!pause_reg[gi])
          to_cnt_reg <= '0;
        else if (state_reg == S_ACTIVE && !stall_hit[gi])
          to_cnt_reg <= to_cnt_reg + 1'b1;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset)
      stall_to_reg <= '0;
    else
      stall_to_reg <= stall_to_reg | stall_hit;
  end

  assign stall_any = |stall_hit;
  assign stall_to  = stall_to_reg;
`else
  assign stall_any = 1'b0;
`endif

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_RESET;
      pause_reg      <= '0;
      error_full_reg <= '0;
      cfg_err_reg    <= 1'b0;
      idle_reg       <= 1'b0;
      af_reg         <= AF_DEF;
      ae_reg         <= AE_DEF;
      cand_af_reg    <= AF_DEF;
      cand_ae_reg    <= AE_DEF;
      sampled_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pause_reg      <= pause_next;
      error_full_reg <= error_full_next;
      cfg_err_reg    <= cfg_err_next;
      idle_reg       <= idle_next;
      af_reg         <= af_next;
      ae_reg         <= ae_next;
      cand_af_reg    <= cand_af_next;
      cand_ae_reg    <= cand_ae_next;
      sampled_reg    <= sampled_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_RESET: state_next = S_INIT;
      S_INIT:  if (!init) state_next = S_IDLE;
      S_IDLE, S_ACTIVE: begin
        // full (or a stall timeout) beats init; IDLE and ACTIVE share the rule
        if (any_full || stall_any) state_next = S_ERROR;
        else if (init)             state_next = S_INIT;
        else if (any_busy)         state_next = S_ACTIVE;
        else                       state_next = S_IDLE;
      end
      S_ERROR: state_next = S_ERROR;
      default: state_next = S_RESET;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    pause_next      = '0;
    error_full_next = error_full_reg;
    cfg_err_next    = cfg_err_reg;
    af_next         = af_reg;
    ae_next         = ae_reg;
    cand_af_next    = cand_af_reg;
    cand_ae_next    = cand_ae_reg;
    sampled_next    = sampled_reg;
    idle_next       = (state_next == S_IDLE);

    if (in_run || state_reg == S_ERROR)
      error_full_next = error_full_reg | fifo_full;

    if (state_next == S_ERROR)
      pause_next = '1;
    else if (in_run && (state_next == S_IDLE || state_next == S_ACTIVE))
      pause_next = hyst;

    if (state_reg == S_INIT) begin
      if (init) begin
        cand_af_next = umbral_af_in;
        cand_ae_next = umbral_ae_in;
        sampled_next = 1'b1;
      end else if (sampled_reg) begin
        // Commit on leaving INIT; an inverted window falls back to defaults.
        sampled_next = 1'b0;
        if (cand_ae_reg >= cand_af_reg) begin
          af_next      = AF_DEF;
          ae_next      = AE_DEF;
          cfg_err_next = 1'b1;
        end else begin
          af_next      = cand_af_reg;
          ae_next      = cand_ae_reg;
          cfg_err_next = 1'b0;
        end
      end
    end
  end

  assign state      = state_reg;
  assign pause      = pause_reg;
  assign error_full = error_full_reg;
  assign cfg_err    = cfg_err_reg;
  assign idle       = idle_reg;

endmodule

// File: tb/tb_fifo_flow_ctrl_fsm.sv
module tb_fifo_flow_ctrl_fsm;

  localparam int N = 4;
  localparam int W = 3;

  logic         clk;
  logic         reset;
  logic         init;
  logic [W-1:0] umbral_af_in;
  logic [W-1:0] umbral_ae_in;
  logic [N*W-1:0] fifo_count;
  logic [N-1:0] fifo_full;
  logic [N-1:0] fifo_empty;
  logic [2:0]   state;
  logic [N-1:0] pause;
  logic [N-1:0] error_full;
  logic         cfg_err;
  logic         idle;
`ifdef FIFO_FLOW_STALL_TIMEOUT_EN
  logic [N-1:0] stall_to;
`endif

  fifo_flow_ctrl_fsm dut (
    .clk(clk),
    .reset(reset),
    .init(init),
    .umbral_af_in(umbral_af_in),
    .umbral_ae_in(umbral_ae_in),
    .fifo_count(fifo_count),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty),
    .state(state),
    .pause(pause),
    .error_full(error_full),
    .cfg_err(cfg_err),
`ifdef FIFO_FLOW_STALL_TIMEOUT_EN
    .stall_to(stall_to),
`endif
    .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st;
    int pz;
    int ef;
    int cf;
    int il;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int txn = 0;

  // Reference model: plain integers following the behavioural rules
  int m_st;
  int m_pause[N];
  int m_err[N];
  int m_cfg;
  int m_af, m_ae;
  int m_cand_af, m_cand_ae;
  int m_have_cand;

  function automatic logic [N*W-1:0] pack4(input int c0, input int c1, input int c2, input int c3);
    logic [N*W-1:0] v;
    v = '0;
    v[0*W +: W] = W'(c0);
    v[1*W +: W] = W'(c1);
    v[2*W +: W] = W'(c2);
    v[3*W +: W] = W'(c3);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s txn=%0d got=%0d expected=%0d", name, txn, act, req);
    end
  endtask

  // One clock of stimulus; the model predicts the outputs after the edge.
  task automatic step(input bit r, input bit ini, input int af_in, input int ae_in,
                      input logic [N*W-1:0] cnt, input logic [N-1:0] full);
    exp_t e;
    int c;
    int busy;
    int anyfull;
    @(negedge clk);
    reset = r;
    init = ini;
    umbral_af_in = W'(af_in);
    umbral_ae_in = W'(ae_in);
    fifo_count = cnt;
    fifo_full = full;
    for (int i = 0; i < N; i++) fifo_empty[i] = (cnt[i*W +: W] == 0);

    busy = 0;
    anyfull = (full != 0) ? 1 : 0;
    for (int i = 0; i < N; i++) if (cnt[i*W +: W] != 0) busy = 1;

    if (r) begin
      m_st = 0; m_cfg = 0; m_af = 6; m_ae = 1; m_have_cand = 0;
      for (int i = 0; i < N; i++) begin m_pause[i] = 0; m_err[i] = 0; end
    end else if (m_st == 0) begin
      m_st = 1; m_have_cand = 0;
      for (int i = 0; i < N; i++) m_pause[i] = 0;
    end else if (m_st == 1) begin
      for (int i = 0; i < N; i++) m_pause[i] = 0;
      if (ini) begin
        m_cand_af = af_in; m_cand_ae = ae_in; m_have_cand = 1;
      end else begin
        m_st = 2;
        if (m_have_cand == 1) begin
          if (m_cand_ae >= m_cand_af) begin m_af = 6; m_ae = 1; m_cfg = 1; end
          else begin m_af = m_cand_af; m_ae = m_cand_ae; m_cfg = 0; end
        end
      end
    end else if (m_st == 2 || m_st == 3) begin
      for (int i = 0; i < N; i++) if (full[i]) m_err[i] = 1;
      if (anyfull == 1) begin
        m_st = 4;
        for (int i = 0; i < N; i++) m_pause[i] = 1;
      end else if (ini) begin
        m_st = 1; m_have_cand = 0;
        for (int i = 0; i < N; i++) m_pause[i] = 0;
      end else begin
        for (int i = 0; i < N; i++) begin
          c = int'(cnt[i*W +: W]);
          if (c >= m_af) m_pause[i] = 1;
          else if (c <= m_ae) m_pause[i] = 0;
        end
        m_st = (busy == 1) ? 3 : 2;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (full[i]) m_err[i] = 1;
        m_pause[i] = 1;
      end
    end

    e.st = m_st;
    e.pz = 0;
    e.ef = 0;
    for (int i = 0; i < N; i++) begin
      e.pz += m_pause[i] << i;
      e.ef += m_err[i] << i;
    end
    e.cf = m_cfg;
    e.il = (m_st == 2) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are sampled 1 time unit after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        chk("state", int'(state), e.st);
        chk("pause", int'(pause), e.pz);
        chk("error_full", int'(error_full), e.ef);
        chk("cfg_err", int'(cfg_err), e.cf);
        chk("idle", int'(idle), e.il);
        $display("txn %0d: state=%0d pause=%b error_full=%b cfg_err=%0d idle=%0d",
                 txn, state, pause, error_full, cfg_err, idle);
      end
    end
  end

  initial begin
    int cs[N];
    logic [N-1:0] fl;
    reset = 1'b1; init = 1'b0; umbral_af_in = '0; umbral_ae_in = '0;
    fifo_count = '0; fifo_full = '0; fifo_empty = '1;

    // Reset, configure 5/2, reach IDLE
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 5, 2, 0, 0);
    step(0, 1, 5, 2, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Hysteresis on channel 1, then back to IDLE
    step(0, 0, 0, 0, pack4(0, 0, 0, 0), 0);
    step(0, 0, 0, 0, pack4(0, 3, 0, 0), 0);
    step(0, 0, 0, 0, pack4(0, 5, 0, 0), 0);
    step(0, 0, 0, 0, pack4(0, 4, 0, 0), 0);
    step(0, 0, 0, 0, pack4(0, 3, 0, 0), 0);
    step(0, 0, 0, 0, pack4(0, 2, 0, 0), 0);
    step(0, 0, 0, 0, pack4(0, 1, 0, 0), 0);
    step(0, 0, 0, 0, pack4(0, 0, 0, 0), 0);

    // Inverted window is rejected -> defaults 6/1
    step(0, 1, 2, 4, 0, 0);
    step(0, 1, 2, 4, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, pack4(5, 0, 0, 0), 0);
    step(0, 0, 0, 0, pack4(6, 0, 0, 0), 0);
    step(0, 0, 0, 0, pack4(2, 0, 0, 0), 0);
    step(0, 0, 0, 0, pack4(1, 0, 0, 0), 0);

    // INIT visit without init rising keeps thresholds
    step(0, 1, 3, 1, pack4(1, 0, 0, 0), 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, pack4(0, 0, 6, 0), 0);

    // Full beats init, then error_full accumulates, init ignored, reset
    step(0, 0, 0, 0, pack4(0, 0, 0, 1), 0);
    step(0, 1, 0, 0, pack4(0, 0, 7, 1), 4'b0100);
    step(0, 0, 0, 0, pack4(0, 0, 7, 1), 0);
    step(0, 0, 0, 0, pack4(7, 0, 7, 1), 4'b0001);
    step(0, 1, 5, 2, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, pack4(0, 0, 0, 6), 0);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N; i++)
        cs[i] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 7));
      fl = ($urandom_range(0, 39) == 0) ? N'($urandom_range(1, 15)) : '0;
      step(($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           pack4(cs[0], cs[1], cs[2], cs[3]), fl);
    end

    @(negedge clk);
    @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_flow_ctrl_fsm.md
Name: fifo_flow_ctrl_fsm

Overview:
Parametrised successor of the single-channel FIFO flow-control FSM. It supervises NCH FIFOs from their occupancy counts and computes per-channel almost-full/almost-empty itself, using programmable thresholds with hysteresis. It drives per-channel pause and error flags plus a global state code. It sits between the FIFO bank and the upstream arbiter, which must stop pushing into any channel whose pause bit is set.

Parameters:
NCH, 4, number of supervised FIFO channels (1..8)
CNT_W, 3, width of each FIFO occupancy count and of each threshold
AF_DEFAULT, 6, almost-full threshold loaded at reset and used on bad configuration
AE_DEFAULT, 1, almost-empty threshold loaded at reset and used on bad configuration

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
init  in  1  configuration request; thresholds are sampled while in INIT
umbral_af_in  in  CNT_W  almost-full threshold to program
umbral_ae_in  in  CNT_W  almost-empty threshold to program
fifo_count  in  NCH*CNT_W  occupancy of each channel; channel i is bits [i*CNT_W +: CNT_W]
fifo_full  in  NCH  per-channel full flag
fifo_empty  in  NCH  per-channel empty flag
state  out  3  encoding: 0 RESET, 1 INIT, 2 IDLE, 3 ACTIVE, 4 ERROR
pause  out  NCH  per-channel backpressure, registered
error_full  out  NCH  sticky per-channel overflow flags, registered
cfg_err  out  1  last configuration was rejected
idle  out  1  high exactly when state==IDLE

Behaviour:
- Reset is synchronous and active-high, clock is clk. While reset is high: state=RESET, pause=0, error_full=0, cfg_err=0, af_reg=AF_DEFAULT, ae_reg=AE_DEFAULT.
- All outputs are registered. Every input affects outputs at the next rising edge (1-cycle latency).
- RESET: go to INIT on the first edge with reset low. Unconditional.
- INIT:
  - While init=1, sample af_reg/ae_reg candidates from umbral_*_in every cycle. Stay in INIT.
  - On the first edge with init=0, go to IDLE.
  - Commit rule: if the last sampled ae >= af, load the defaults and set cfg_err=1. Otherwise commit the sampled values and set cfg_err=0.
  - If init never rose during this INIT visit, the current af_reg/ae_reg are kept.
  - pause held at 0.
- IDLE, evaluated in priority order:
  - any fifo_full -> ERROR
  - init -> INIT
  - any channel not empty -> ACTIVE
  - else stay in IDLE
- ACTIVE, evaluated in priority order:
  - any fifo_full -> ERROR
  - init -> INIT
  - all fifo_empty -> IDLE
  - else stay in ACTIVE
- ERROR: absorbing. Only reset exits it. Ignores init. pause forced to all-ones.
- error_full[i]:
  - Set on any edge where fifo_full[i]=1 and state is IDLE or ACTIVE.
  - Keeps ORing in newly full channels on the entry edge and while in ERROR.
  - Never cleared except by reset.
- pause[i] in IDLE/ACTIVE uses hysteresis, with unsigned compares at CNT_W width:
  - set when count_i >= af_reg
  - cleared when count_i <= ae_reg
  - otherwise held
- Simultaneous events:
  - full has priority over init.
  - init in IDLE/ACTIVE clears pause on INIT entry.
- Reset mid-operation:
  - Reset wins over every condition.
  - Thresholds revert to the defaults.

Optional Feature:
FIFO_FLOW_STALL_TIMEOUT_EN:
- When defined, adds parameter TIMEOUT (default 16) and output stall_to (NCH bits, sticky until reset).
- Each channel has a counter that increments while pause[i]=1 in ACTIVE and clears when pause[i]=0.
- When the counter reaches TIMEOUT: stall_to[i] is set and the FSM goes to ERROR. error_full is unaffected.
- When not defined: no counters, no stall_to port, and pause may be held indefinitely.

Test Plan:
- Reset then init=1 for 2 cycles with af_in=5, ae_in=2, then init=0 -> state sequence 0,1,1,1,2; cfg_err=0; thresholds 5/2.
- Config with af_in=2, ae_in=4 -> cfg_err=1; pause thresholds 6/1. Channel 0 count 6 -> pause[0]=1 the next cycle.
- Thresholds 5/2. Ch1 count 0,3,5,4,3,2,1 -> ACTIVE after the first nonzero count. pause[1] goes 0,0,1,1,1,0,0, each one cycle delayed. Back to IDLE when all empty.
- In ACTIVE, fifo_full=4'b0100 with init=1 on the same edge -> ERROR (not INIT); error_full=4'b0100; pause=4'b1111. A later full[0] makes error_full=4'b0101.
- In ERROR, pulse init -> no change. Then reset=1 for 1 cycle -> state=0, all outputs 0, thresholds 6/1.
- With FIFO_FLOW_STALL_TIMEOUT_EN and TIMEOUT=4: hold ch2 count at af -> stall_to[2]=1 and state=4 four cycles after pause[2] rises.
